// File: rtl/ln_stage5_writeback.sv
// LayerNorm writeback: captures tagged result beats into a ping-pong buffer and
// drains each completed vector in ascending beat order on a valid/ready stream.
module ln_stage5_writeback #(
  parameter int DATA_W    = 1024,
  parameter int ADDR_W    = 6,
  parameter int NUM_BEATS = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic              o_m_last,
  output logic [1:0]        o_buf_free,
  output logic              o_err_ovf,
  output logic              o_err_dup,
  output logic              o_err_range,
  input  logic              i_clr_err
);

  localparam int CNT_W = $clog2(NUM_BEATS + 1);
  localparam int DEPTH = 2 ** (ADDR_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

  logic [DATA_W-1:0]            r_mem [DEPTH];
  logic [1:0][NUM_BEATS-1:0]    r_bitmap;
  logic [1:0][CNT_W-1:0]        r_count;
  logic [1:0]                   r_full;
  logic                         r_wr_sel;
  logic                         r_rd_sel;
  logic                         r_err_ovf;
  logic                         r_err_dup;
  logic                         r_err_range;

  state_t                       r_state;
  logic [DATA_W-1:0]            r_pf;
  logic [DATA_W-1:0]            r_m_data;
  logic [ADDR_W-1:0]            r_m_addr;
  logic                         r_m_valid;
  logic                         r_m_last;

  logic                         w_in_range;
  logic                         w_wr_ok;
  logic                         w_dup;
  logic                         w_new;
  logic                         w_fill_done;
  logic                         w_hs;
  logic                         w_drain_done;
  logic                         w_other_full;
  logic                         w_fetch_buf;
  logic [ADDR_W-1:0]            w_fetch_addr;
  logic                         w_fwd;

  assign w_in_range   = (32'(i_wr_addr) < NUM_BEATS);
  assign w_wr_ok      = i_wr_valid && !r_full[r_wr_sel] && w_in_range;
  assign w_dup        = w_wr_ok && r_bitmap[r_wr_sel][i_wr_addr];
  assign w_new        = w_wr_ok && !r_bitmap[r_wr_sel][i_wr_addr];
  assign w_fill_done  = w_new && (r_count[r_wr_sel] == CNT_W'(NUM_BEATS - 1));
  assign w_hs         = r_m_valid && i_m_ready;
  assign w_drain_done = w_hs && r_m_last;
  // A fill completing this cycle on the other buffer counts as full for the drain decision.
  assign w_other_full = r_full[~r_rd_sel] || (w_fill_done && (r_wr_sel != r_rd_sel));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bitmap    <= '0;
      r_count     <= '0;
      r_full      <= '0;
      r_wr_sel    <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_dup   <= 1'b0;
      r_err_range <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_drain_done && (r_rd_sel == 1'(b))) begin
          r_bitmap[b] <= '0;
          r_count[b]  <= '0;
          r_full[b]   <= 1'b0;
        end else if (w_new && (r_wr_sel == 1'(b))) begin
          r_bitmap[b][i_wr_addr] <= 1'b1;
          r_count[b]             <= r_count[b] + CNT_W'(1);
          if (w_fill_done) r_full[b] <= 1'b1;
        end
      end
      if (w_fill_done) r_wr_sel <= ~r_wr_sel;
      r_err_ovf   <= (r_err_ovf && !i_clr_err) || (i_wr_valid && r_full[r_wr_sel]);
      r_err_dup   <= (r_err_dup && !i_clr_err) || w_dup;
      r_err_range <= (r_err_range && !i_clr_err) || (i_wr_valid && !r_full[r_wr_sel] && !w_in_range);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_mem[{r_wr_sel, i_wr_addr}] <= i_wr_data;
  end

  // Prefetch address: always one beat ahead of the output register.
  always_comb begin
    w_fetch_buf  = r_rd_sel;
    w_fetch_addr = '0;
    case (r_state)
      S_LOAD: w_fetch_addr = ADDR_W'(1);
      S_SEND: begin
        if (w_drain_done)  w_fetch_buf  = ~r_rd_sel;
        else if (w_hs)     w_fetch_addr = r_m_addr + ADDR_W'(2);
        else               w_fetch_addr = r_m_addr + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  assign w_fwd = w_wr_ok && ({r_wr_sel, i_wr_addr} == {w_fetch_buf, w_fetch_addr});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_rd_sel  <= 1'b0;
      r_pf      <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_addr  <= '0;
      r_m_last  <= 1'b0;
    end else begin
      r_pf <= w_fwd ? i_wr_data : r_mem[{w_fetch_buf, w_fetch_addr}];
      case (r_state)
        S_IDLE: if (r_full[r_rd_sel]) r_state <= S_LOAD;
        S_LOAD: begin
          r_state   <= S_SEND;
          r_m_valid <= 1'b1;
          r_m_data  <= r_pf;
          r_m_addr  <= '0;
          r_m_last  <= (NUM_BEATS == 1);
        end
        S_SEND: begin
          if (w_drain_done) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_rd_sel  <= ~r_rd_sel;
            r_state   <= w_other_full ? S_LOAD : S_IDLE;
          end else if (w_hs) begin
            r_m_data <= r_pf;
            r_m_addr <= r_m_addr + ADDR_W'(1);
            r_m_last <= ((32'(r_m_addr) + 1) == (NUM_BEATS - 1));
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_m_valid   = r_m_valid;
  assign o_m_data    = r_m_data;
  assign o_m_addr    = r_m_addr;
  assign o_m_last    = r_m_last;
  assign o_buf_free  = ~r_full;
  assign o_err_ovf   = r_err_ovf;
  assign o_err_dup   = r_err_dup;
  assign o_err_range = r_err_range;

endmodule

// File: tb/tb_ln_stage5_writeback.sv
// Directed bench for ln_stage5_writeback: table of fill/drain scenarios plus
// hand-written ping-pong, duplicate, error-clear and reset-mid-drain sequences.
module tb_ln_stage5_writeback;

  localparam int DW = 1024;
  localparam int AW = 6;
  localparam int NB = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr;
  logic          m_last;
  logic [1:0]    buf_free;
  logic          err_ovf;
  logic          err_dup;
  logic          err_range;
  logic          clr_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] expData [0:127];

  typedef struct {
    int         order;
    int         mult;
    logic [3:0] pat;
    int         expDur;
  } vec_t;

  vec_t vecs [4];

  ln_stage5_writeback #(.DATA_W(DW), .ADDR_W(AW), .NUM_BEATS(NB)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wr_valid  (wr_valid),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .o_m_valid   (m_valid),
    .i_m_ready   (m_ready),
    .o_m_data    (m_data),
    .o_m_addr    (m_addr),
    .o_m_last    (m_last),
    .o_buf_free  (buf_free),
    .o_err_ovf   (err_ovf),
    .o_err_dup   (err_dup),
    .o_err_range (err_range),
    .i_clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] mkData(input int tag, input int mult);
    logic [DW-1:0] d;
    for (int l = 0; l < 64; l++) d[l*16 +: 16] = 16'(tag * mult + l * 257);
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkData(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual_low=%016h expected_low=%016h (cycle %0d)", name, act[63:0], exp[63:0], cyc);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] tag, input logic [DW-1:0] data, input logic clr);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = tag;
    wr_data  = data;
    clr_err  = clr;
  endtask

  task automatic endWrite();
    @(negedge clk);
    wr_valid = 1'b0;
    clr_err  = 1'b0;
  endtask

  task automatic pulseClr();
    @(negedge clk);
    wr_valid = 1'b0;
    clr_err  = 1'b1;
    @(negedge clk);
    clr_err  = 1'b0;
  endtask

  // order 0: ascending, 1: descending, 2: scrambled (tag = 37*i mod 64)
  task automatic writeVector(input int order, input int mult, input int base, output int lastCap);
    int tag;
    lastCap = -1;
    for (int i = 0; i < NB; i++) begin
      tag = (order == 0) ? i : (order == 1) ? (NB - 1 - i) : ((i * 37) % NB);
      expData[base + tag] = mkData(tag, mult);
      applyStimulus(AW'(tag), mkData(tag, mult), 1'b0);
      lastCap = cyc + 1;
    end
  endtask

  // Drains one vector comparing each presented beat with expData[base+idx];
  // stops early (without handshaking) once beat stopAt is presented.
  task automatic drainVector(input int base, input logic [3:0] pat, input int stopAt,
                             input logic [1:0] expFree, output int first, output int lastHs);
    int idx = 0;
    int k = 0;
    int guard = 0;
    bit stop = 0;
    first  = -1;
    lastHs = -1;
    while (!stop && idx < NB && guard < 4000) begin
      @(negedge clk);
      guard++;
      m_ready = 1'b0;
      if (m_valid) begin
        if (first < 0) first = cyc;
        checkOutput("beat_addr", 64'(m_addr), 64'(idx));
        checkOutput("beat_last", 64'(m_last), 64'(idx == NB - 1));
        checkData("beat_data", m_data, expData[base + idx]);
        if (idx == stopAt) stop = 1;
        else begin
          m_ready = pat[k % 4];
          k++;
          if (m_ready) begin
            idx++;
            if (idx == NB) lastHs = cyc + 1;
          end
        end
      end
    end
    checkOutput("drain_complete", 64'(stop || idx == NB), 64'd1);
    if (!stop) begin
      @(negedge clk);
      m_ready = 1'b0;
      checkOutput("post_drain_valid", 64'(m_valid), 64'd0);
      checkOutput("post_drain_free", 64'(buf_free), 64'(expFree));
    end
  endtask

  initial begin
    int lastCap;
    int first;
    int lastHs;

    vecs[0] = '{0, 1, 4'b1111, 64};
    vecs[1] = '{1, 3, 4'b1111, 64};
    vecs[2] = '{0, 5, 4'b1001, 128};
    vecs[3] = '{2, 7, 4'b1111, 64};

    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    m_ready  = 1'b0;
    clr_err  = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_buf_free", 64'(buf_free), 64'd3);
    checkOutput("rst_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_last", 64'(m_last), 64'd0);
    checkOutput("rst_addr", 64'(m_addr), 64'd0);
    checkData("rst_data", m_data, '0);
    checkOutput("rst_errs", 64'({err_ovf, err_dup, err_range}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_free", 64'(buf_free), 64'd3);

    // Table-driven fill/drain scenarios: ordering, lane values, ready patterns.
    for (int v = 0; v < 4; v++) begin
      writeVector(vecs[v].order, vecs[v].mult, 0, lastCap);
      endWrite();
      drainVector(0, vecs[v].pat, NB, 2'b11, first, lastHs);
      checkOutput("latency", 64'(first - lastCap), 64'd2);
      checkOutput("duration", 64'(lastHs - first), 64'(vecs[v].expDur));
    end

    // Ping-pong: two back-to-back vectors with the consumer stalled.
    m_ready = 1'b0;
    writeVector(0, 1, 0, lastCap);
    writeVector(0, 2, 64, lastCap);
    endWrite();
    checkOutput("pp_both_full", 64'(buf_free), 64'd0);
    checkOutput("pp_no_ovf_yet", 64'(err_ovf), 64'd0);
    applyStimulus(AW'(0), {64{16'hDEAD}}, 1'b0);
    endWrite();
    checkOutput("pp_ovf", 64'(err_ovf), 64'd1);
    drainVector(0, 4'b1111, NB, 2'b01, first, lastHs);
    drainVector(64, 4'b1111, NB, 2'b11, first, lastHs);
    pulseClr();
    checkOutput("ovf_cleared", 64'(err_ovf), 64'd0);

    // Duplicate tag 5: second write overwrites, fill completes only on 64 unique tags.
    expData[5] = {64{16'hAAAA}};
    applyStimulus(AW'(5), {64{16'hAAAA}}, 1'b0);
    for (int t = 0; t < 63; t++) begin
      if (t != 5) begin
        expData[t] = mkData(t, 4);
        applyStimulus(AW'(t), mkData(t, 4), 1'b0);
      end
    end
    expData[5] = {64{16'hBBBB}};
    applyStimulus(AW'(5), {64{16'hBBBB}}, 1'b0);
    endWrite();
    checkOutput("dup_flag", 64'(err_dup), 64'd1);
    checkOutput("dup_not_full", 64'(buf_free), 64'd3);
    checkOutput("dup_no_valid", 64'(m_valid), 64'd0);
    expData[63] = mkData(63, 4);
    applyStimulus(AW'(63), mkData(63, 4), 1'b0);
    lastCap = cyc + 1;
    endWrite();
    drainVector(0, 4'b1111, NB, 2'b11, first, lastHs);
    checkOutput("dup_latency", 64'(first - lastCap), 64'd2);
    pulseClr();
    checkOutput("dup_cleared", 64'(err_dup), 64'd0);

    // Clear coinciding with a new duplicate: the new error wins.
    applyStimulus(AW'(0), mkData(0, 6), 1'b0);
    expData[0] = mkData(0, 7);
    applyStimulus(AW'(0), mkData(0, 7), 1'b1);
    endWrite();
    checkOutput("clr_vs_dup", 64'(err_dup), 64'd1);
    pulseClr();
    checkOutput("dup_cleared2", 64'(err_dup), 64'd0);

    // Reset in the middle of a drain, then a fresh vector.
    for (int t = 1; t < NB; t++) begin
      expData[t] = mkData(t, 8);
      applyStimulus(AW'(t), mkData(t, 8), 1'b0);
    end
    endWrite();
    drainVector(0, 4'b1111, 20, 2'b11, first, lastHs);
    checkOutput("pre_reset_addr", 64'(m_addr), 64'd20);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_valid", 64'(m_valid), 64'd0);
    checkOutput("mid_rst_free", 64'(buf_free), 64'd3);
    checkOutput("mid_rst_addr", 64'(m_addr), 64'd0);
    rst_n = 1'b1;
    writeVector(0, 9, 0, lastCap);
    endWrite();
    drainVector(0, 4'b1111, NB, 2'b11, first, lastHs);
    checkOutput("rst_refill_latency", 64'(first - lastCap), 64'd2);
    checkOutput("rst_refill_duration", 64'(lastHs - first), 64'd64);
    checkOutput("final_errs", 64'({err_ovf, err_dup, err_range}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
